// File: rtl/alu_serial_driver_if.sv
// ---------------------------------------------------------------------------
// alu_serial_driver_if
// Bundles the two buses of the bit-serial ALU driver into one interface.
//   Request side (control path <-> driver):
//     start, op, a, b            request and operands into the driver
//     busy, done                 handshake status from the driver
//     result, carry_out,
//     overflow, zero             final word result and flags
//   Slice side (driver <-> shared 1-bit ALU slice):
//     s_ai, s_bi, s_ci, s_aluop,
//     s_lessi                    bit operands, carry-in and op select
//     s_ri, s_ci_1               slice result bit and carry-out
// Modports:
//   slave  - the driver itself
//   master - the environment (control path plus the slice instance)
// ---------------------------------------------------------------------------
interface alu_serial_driver_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  logic             s_ai;
  logic             s_bi;
  logic             s_ci;
  logic [2:0]       s_aluop;
  logic             s_lessi;
  logic             s_ri;
  logic             s_ci_1;

  modport slave (
    input  start, op, a, b, s_ri, s_ci_1,
    output busy, done, result, carry_out, overflow, zero,
           s_ai, s_bi, s_ci, s_aluop, s_lessi
  );

  modport master (
    output start, op, a, b, s_ri, s_ci_1,
    input  busy, done, result, carry_out, overflow, zero,
           s_ai, s_bi, s_ci, s_aluop, s_lessi
  );

endinterface

// File: rtl/alu_serial_driver.sv
// ---------------------------------------------------------------------------
// alu_serial_driver
// Bit-serial initiator for a single shared 1-bit ALU slice. A full-width
// operation is accepted on start, then fed to the slice LSB first, one bit
// per clock, recirculating the slice carry. The result word is rebuilt from
// the slice result bits and the flags are derived at the end.
// Ports:
//   clk    - system clock, all state changes on the rising edge
//   reset  - synchronous active-high reset, aborts any operation in flight
//   bus    - alu_serial_driver_if.slave: request handshake, result/flags and
//            the slice drive/return signals
// Timing: done pulses WIDTH+1 cycles after the accepting edge; the next
// start can be accepted at the end of the done cycle.
// ---------------------------------------------------------------------------
module alu_serial_driver #(
  parameter int WIDTH = 32
) (
  input logic                clk,
  input logic                reset,
  alu_serial_driver_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] rSh_q, rSh_d;
  logic [2:0]       opR_q, opR_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cMsbIn_q, cMsbIn_d;
  logic             sumMsb_q, sumMsb_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carryOut_q, carryOut_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] finalResult;
  logic             inRun;

  // State and datapath registers. Reset returns everything to the idle
  // picture: no result, zero flag set, nothing pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      aSh_q      <= '0;
      bSh_q      <= '0;
      rSh_q      <= '0;
      opR_q      <= '0;
      cnt_q      <= '0;
      c_q        <= 1'b0;
      cMsbIn_q   <= 1'b0;
      sumMsb_q   <= 1'b0;
      cout_q     <= 1'b0;
      result_q   <= '0;
      carryOut_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      aSh_q      <= aSh_d;
      bSh_q      <= bSh_d;
      rSh_q      <= rSh_d;
      opR_q      <= opR_d;
      cnt_q      <= cnt_d;
      c_q        <= c_d;
      cMsbIn_q   <= cMsbIn_d;
      sumMsb_q   <= sumMsb_d;
      cout_q     <= cout_d;
      result_q   <= result_d;
      carryOut_q <= carryOut_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic. IDLE waits for start and loads the operands, RUN
  // pushes one bit pair through the slice per clock while collecting the
  // result bits, FIN turns the collected bits and carries into the visible
  // result and flags. The carry register starts at op[2] so subtraction
  // gets its +1 through the LSB carry-in; SLT is just the sign of A-B.
  always_comb begin
    state_d     = state_q;
    aSh_d       = aSh_q;
    bSh_d       = bSh_q;
    rSh_d       = rSh_q;
    opR_d       = opR_q;
    cnt_d       = cnt_q;
    c_d         = c_q;
    cMsbIn_d    = cMsbIn_q;
    sumMsb_d    = sumMsb_q;
    cout_d      = cout_q;
    result_d    = result_q;
    carryOut_d  = carryOut_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    done_d      = 1'b0;
    finalResult = (opR_q == OP_SLT) ? WIDTH'(sumMsb_q) : rSh_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          aSh_d   = bus.a;
          bSh_d   = bus.b;
          opR_d   = bus.op;
          cnt_d   = '0;
          c_d     = bus.op[2];
          state_d = RUN;
        end
      end

      RUN: begin
        aSh_d = aSh_q >> 1;
        bSh_d = bSh_q >> 1;
        rSh_d = {bus.s_ri, rSh_q[WIDTH-1:1]};
        c_d   = bus.s_ci_1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 2)) begin
          cMsbIn_d = bus.s_ci_1;
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          sumMsb_d = bus.s_ri;
          cout_d   = bus.s_ci_1;
          state_d  = FIN;
        end
      end

      FIN: begin
        result_d   = finalResult;
        carryOut_d = opR_q[1] & cout_q;
        overflow_d = ((opR_q == OP_ADD) || (opR_q == OP_SUB)) & (cMsbIn_q ^ cout_q);
        zero_d     = (finalResult == '0);
        done_d     = 1'b1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Slice drive is only live during RUN so the shared slice sees a quiet
  // bus otherwise. SLT runs the slice as a subtract; the less-than bit is
  // taken from the MSB sum instead of the slice less input.
  assign inRun       = (state_q == RUN);
  assign bus.s_ai    = inRun & aSh_q[0];
  assign bus.s_bi    = inRun & bSh_q[0];
  assign bus.s_ci    = inRun & c_q;
  assign bus.s_aluop = !inRun ? 3'b000 : ((opR_q == OP_SLT) ? OP_SUB : opR_q);
  assign bus.s_lessi = 1'b0;

  // Request-side outputs come straight from the registers.
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carryOut_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

endmodule
